// File: rtl/cache_nway_lru.sv
// N-way set-associative write-back / write-allocate data cache with true-LRU
// replacement, 4-word lines refilled from a 128-bit block memory.
module cache_nway_lru #(
    parameter int  ADDR_W = 30,
    parameter int  SETS   = 4,
    parameter int  WAYS   = 2,
    localparam int IDX_W  = $clog2(SETS),
    localparam int AGE_W  = $clog2(WAYS),
    localparam int TAG_W  = ADDR_W - 2 - IDX_W
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              proc_read,
    input  logic              proc_write,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [31:0]       proc_wdata,
    output logic [31:0]       proc_rdata,
    output logic              proc_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-3:0] mem_addr,
    input  logic [127:0]      mem_rdata,
    output logic [127:0]      mem_wdata,
    input  logic              mem_ready,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        ALLOCATE   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            next_state_s;

    logic              valid_r [SETS][WAYS];
    logic              dirty_r [SETS][WAYS];
    logic [TAG_W-1:0]  tag_r   [SETS][WAYS];
    logic [127:0]      data_r  [SETS][WAYS];
    logic [AGE_W-1:0]  age_r   [SETS][WAYS];

    logic [AGE_W-1:0]  victim_r;
    logic              replay_r;
    logic [31:0]       hit_cnt_r;
    logic [31:0]       miss_cnt_r;

    logic [1:0]        offset_s;
    logic [IDX_W-1:0]  index_s;
    logic [TAG_W-1:0]  tag_s;
    logic              req_s;
    logic              hit_s;
    logic [AGE_W-1:0]  hit_way_s;
    logic              any_inv_s;
    logic [AGE_W-1:0]  inv_way_s;
    logic [AGE_W-1:0]  lru_way_s;
    logic [AGE_W-1:0]  victim_s;
    logic [31:0]       hit_word_s;

    // New age of one way when a way whose previous age was touched_age is accessed
    function automatic logic [AGE_W-1:0] lru_next(input logic [AGE_W-1:0] cur,
                                                  input logic [AGE_W-1:0] touched_age,
                                                  input logic             is_touched);
        logic [AGE_W-1:0] res;
        if (is_touched) begin
            res = {AGE_W{1'b0}};
        end else if (cur < touched_age) begin
            res = cur + AGE_W'(1);
        end else begin
            res = cur;
        end
        return res;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign offset_s   = proc_addr[1:0];
    assign index_s    = proc_addr[IDX_W+1:2];
    assign tag_s      = proc_addr[ADDR_W-1:IDX_W+2];
    assign req_s      = proc_read | proc_write;
    assign hit_word_s = data_r[index_s][hit_way_s][{offset_s, 5'b00000} +: 32];
    assign hit_cnt    = hit_cnt_r;
    assign miss_cnt   = miss_cnt_r;

    // Tag match and victim choice: lowest invalid way, else the oldest way
    always_comb begin
        hit_s     = 1'b0;
        hit_way_s = {AGE_W{1'b0}};
        any_inv_s = 1'b0;
        inv_way_s = {AGE_W{1'b0}};
        lru_way_s = {AGE_W{1'b0}};
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_s     = hit_s | (valid_r[index_s][w] && (tag_r[index_s][w] == tag_s));
            hit_way_s = (valid_r[index_s][w] && (tag_r[index_s][w] == tag_s)) ? AGE_W'(w) : hit_way_s;
            any_inv_s = any_inv_s | ~valid_r[index_s][w];
            inv_way_s = (!valid_r[index_s][w]) ? AGE_W'(w) : inv_way_s;
            lru_way_s = (age_r[index_s][w] == AGE_W'(WAYS - 1)) ? AGE_W'(w) : lru_way_s;
        end
        victim_s = any_inv_s ? inv_way_s : lru_way_s;
    end

    // Next-state and Moore/Mealy outputs
    always_comb begin
        next_state_s = state_r;
        proc_stall   = 1'b0;
        proc_rdata   = 32'd0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = {(ADDR_W-2){1'b0}};
        mem_wdata    = 128'd0;
        case (state_r)
            IDLE: begin
                if (req_s && hit_s) begin
                    proc_rdata = hit_word_s;
                end else if (req_s) begin
                    proc_stall   = 1'b1;
                    next_state_s = (valid_r[index_s][victim_s] && dirty_r[index_s][victim_s])
                                   ? WRITE_BACK : ALLOCATE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WRITE_BACK: begin
                proc_stall   = 1'b1;
                mem_write    = 1'b1;
                mem_addr     = {tag_r[index_s][victim_r], index_s};
                mem_wdata    = data_r[index_s][victim_r];
                next_state_s = mem_ready ? ALLOCATE : WRITE_BACK;
            end
            ALLOCATE: begin
                proc_stall   = 1'b1;
                mem_read     = 1'b1;
                mem_addr     = proc_addr[ADDR_W-1:2];
                next_state_s = mem_ready ? IDLE : ALLOCATE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Line storage, LRU ages, victim and replay bookkeeping
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_r[s][w] <= 1'b0;
                    dirty_r[s][w] <= 1'b0;
                    tag_r[s][w]   <= {TAG_W{1'b0}};
                    data_r[s][w]  <= 128'd0;
                    age_r[s][w]   <= AGE_W'(w);
                end
            end
            victim_r <= {AGE_W{1'b0}};
            replay_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    replay_r <= 1'b0;
                    if (req_s && hit_s) begin
                        for (int w = 0; w < WAYS; w++) begin
                            age_r[index_s][w] <= lru_next(age_r[index_s][w],
                                                          age_r[index_s][hit_way_s],
                                                          AGE_W'(w) == hit_way_s);
                        end
                        if (proc_write) begin
                            data_r[index_s][hit_way_s][{offset_s, 5'b00000} +: 32] <= proc_wdata;
                            dirty_r[index_s][hit_way_s] <= 1'b1;
                        end
                    end else if (req_s) begin
                        victim_r <= victim_s;
                    end
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        data_r[index_s][victim_r]  <= mem_rdata;
                        valid_r[index_s][victim_r] <= 1'b1;
                        dirty_r[index_s][victim_r] <= 1'b0;
                        tag_r[index_s][victim_r]   <= tag_s;
                        for (int w = 0; w < WAYS; w++) begin
                            age_r[index_s][w] <= lru_next(age_r[index_s][w],
                                                          age_r[index_s][victim_r],
                                                          AGE_W'(w) == victim_r);
                        end
                        replay_r <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Saturating performance counters; the post-fill replay hit is not counted
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else if (state_r == IDLE && req_s) begin
            if (hit_s && !replay_r) begin
                hit_cnt_r <= sat_inc(hit_cnt_r);
            end else if (!hit_s) begin
                miss_cnt_r <= sat_inc(miss_cnt_r);
            end
        end
    end

endmodule

// File: tb/tb_cache_nway_lru.sv
// Scoreboard bench: a 2-way/4-set and a 4-way/2-set cache share stimulus,
// a block-memory responder checks write-back/refill traffic, a monitor checks reads.
module tb_cache_nway_lru;

    logic         clk = 1'b0;
    logic         proc_reset_n;
    logic         sel;
    logic         req_read, req_write;
    logic [29:0]  req_addr;
    logic [31:0]  req_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    logic [31:0]  a_rdata, b_rdata, a_hit, b_hit, a_miss, b_miss;
    logic         a_stall, b_stall, a_mread, b_mread, a_mwrite, b_mwrite;
    logic [27:0]  a_maddr, b_maddr;
    logic [127:0] a_mwdata, b_mwdata;

    logic [31:0]  m_rdata, m_hit, m_miss;
    logic         m_stall, m_mread, m_mwrite;
    logic [27:0]  m_maddr;
    logic [127:0] m_mwdata;

    always #5 clk = ~clk;

    cache_nway_lru #(.ADDR_W(30), .SETS(4), .WAYS(2)) dut_a (
        .clk(clk), .proc_reset_n(proc_reset_n),
        .proc_read(req_read & ~sel), .proc_write(req_write & ~sel),
        .proc_addr(req_addr), .proc_wdata(req_wdata), .proc_rdata(a_rdata),
        .proc_stall(a_stall), .mem_read(a_mread), .mem_write(a_mwrite),
        .mem_addr(a_maddr), .mem_rdata(mem_rdata), .mem_wdata(a_mwdata),
        .mem_ready(mem_ready & ~sel), .hit_cnt(a_hit), .miss_cnt(a_miss));

    cache_nway_lru #(.ADDR_W(30), .SETS(2), .WAYS(4)) dut_b (
        .clk(clk), .proc_reset_n(proc_reset_n),
        .proc_read(req_read & sel), .proc_write(req_write & sel),
        .proc_addr(req_addr), .proc_wdata(req_wdata), .proc_rdata(b_rdata),
        .proc_stall(b_stall), .mem_read(b_mread), .mem_write(b_mwrite),
        .mem_addr(b_maddr), .mem_rdata(mem_rdata), .mem_wdata(b_mwdata),
        .mem_ready(mem_ready & sel), .hit_cnt(b_hit), .miss_cnt(b_miss));

    assign m_rdata  = sel ? b_rdata  : a_rdata;
    assign m_stall  = sel ? b_stall  : a_stall;
    assign m_mread  = sel ? b_mread  : a_mread;
    assign m_mwrite = sel ? b_mwrite : a_mwrite;
    assign m_maddr  = sel ? b_maddr  : a_maddr;
    assign m_mwdata = sel ? b_mwdata : a_mwdata;
    assign m_hit    = sel ? b_hit    : a_hit;
    assign m_miss   = sel ? b_miss   : a_miss;

    typedef struct {
        logic         is_write;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic         hold;
    } mem_exp_t;

    mem_exp_t     mem_q[$];
    logic [31:0]  rd_q[$];
    logic [127:0] bmem [logic [27:0]];
    int           tests = 0;
    int           fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Backing store: unwritten blocks read as 0xA0000000 | word address
    function automatic logic [127:0] blk(input logic [27:0] a);
        if (bmem.exists(a)) return bmem[a];
        return {32'hA000_0000 | 32'({a, 2'd3}), 32'hA000_0000 | 32'({a, 2'd2}),
                32'hA000_0000 | 32'({a, 2'd1}), 32'hA000_0000 | 32'({a, 2'd0})};
    endfunction

    task automatic exp_mem(input logic w, input logic [27:0] a, input logic [127:0] d, input logic hold);
        mem_exp_t e;
        e.is_write = w; e.addr = a; e.wdata = d; e.hold = hold;
        mem_q.push_back(e);
    endtask

    // Read monitor: every completed read is compared against the queue
    always @(negedge clk) begin
        if (proc_reset_n && req_read && !m_stall) begin
            if (rd_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_read: got %h expected none", m_rdata);
            end else begin
                check("rdata", 128'(m_rdata), 128'(rd_q.pop_front()));
            end
        end
    end

    // Block-memory responder: checks each new request, answers after 2 cycles
    initial begin
        mem_exp_t e;
        logic [27:0] a;
        mem_ready = 1'b0;
        mem_rdata = 128'd0;
        forever begin
            @(negedge clk);
            if (!proc_reset_n || !(m_mread || m_mwrite)) continue;
            if (mem_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_mem_req: got addr %h write %b expected none", m_maddr, m_mwrite);
                e.is_write = m_mwrite; e.addr = m_maddr; e.wdata = m_mwdata; e.hold = 1'b0;
            end else begin
                e = mem_q.pop_front();
                check("mem_kind", 128'(m_mwrite), 128'(e.is_write));
                check("mem_addr", 128'(m_maddr), 128'(e.addr));
                if (e.is_write) check("mem_wdata", m_mwdata, e.wdata);
            end
            if (e.hold) begin
                for (int i = 0; i < 20 && (m_mread || m_mwrite); i++) @(negedge clk);
                continue;
            end
            a = m_maddr;
            @(negedge clk);
            if (m_mwrite) bmem[a] = m_mwdata;
            mem_rdata = blk(a);
            mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0;
        end
    end

    // One processor access held until stall drops; checks the hit/miss outcome
    task automatic access(input logic wr, input logic [29:0] addr, input logic [31:0] wd,
                          input logic exp_miss, input int exp_stalls);
        int stalls = 0;
        bit done = 1'b0;
        req_addr = addr; req_wdata = wd; req_read = !wr; req_write = wr;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!m_stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL timeout: addr %h still stalled, expected completion", addr);
        end
        check("miss_pattern", 128'(stalls > 0), 128'(exp_miss));
        if (exp_stalls >= 0) check("stall_cycles", 128'(stalls), 128'(exp_stalls));
        @(posedge clk); #1;
        req_read = 1'b0; req_write = 1'b0;
    endtask

    task automatic rd(input logic [29:0] addr, input logic [31:0] exp, input logic miss);
        rd_q.push_back(exp);
        access(1'b0, addr, 32'd0, miss, -1);
    endtask

    task automatic cnt(input logic [31:0] h, input logic [31:0] m);
        check("hit_cnt", 128'(m_hit), 128'(h));
        check("miss_cnt", 128'(m_miss), 128'(m));
    endtask

    initial begin
        bit seen;
        proc_reset_n = 1'b0; sel = 1'b0;
        req_read = 1'b0; req_write = 1'b0; req_addr = 30'd0; req_wdata = 32'd0;
        bmem[28'h4] = {32'h0000_4444, 32'h0000_3333, 32'h0000_2222, 32'h0000_1111};
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 128'(m_stall), 128'd0);
        check("rst_mem_rw", 128'({m_mread, m_mwrite}), 128'd0);
        check("rst_mem_addr", 128'(m_maddr), 128'd0);
        check("rst_mem_wdata", m_mwdata, 128'd0);
        check("rst_rdata", 128'(m_rdata), 128'd0);
        cnt(32'd0, 32'd0);
        proc_reset_n = 1'b1;
        @(posedge clk); #1;

        // 2-way, 4 sets: first miss, write hit, LRU eviction, dirty write-backs
        rd_q.push_back(32'h0000_1111);
        exp_mem(1'b0, 28'h4, 128'd0, 1'b0);
        access(1'b0, 30'h10, 32'd0, 1'b1, 3);
        cnt(32'd0, 32'd1);
        access(1'b1, 30'h11, 32'hDEAD_BEEF, 1'b0, 0);
        rd(30'h11, 32'hDEAD_BEEF, 1'b0);
        cnt(32'd2, 32'd1);
        exp_mem(1'b0, 28'h0, 128'd0, 1'b0);
        rd(30'h00, 32'hA000_0000, 1'b1);
        rd(30'h00, 32'hA000_0000, 1'b0);
        exp_mem(1'b1, 28'h4, {32'h0000_4444, 32'h0000_3333, 32'hDEAD_BEEF, 32'h0000_1111}, 1'b0);
        exp_mem(1'b0, 28'h8, 128'd0, 1'b0);
        rd(30'h20, 32'hA000_0020, 1'b1);
        exp_mem(1'b0, 28'h4, 128'd0, 1'b0);
        rd(30'h10, 32'h0000_1111, 1'b1);
        rd(30'h11, 32'hDEAD_BEEF, 1'b0);
        exp_mem(1'b0, 28'h0, 128'd0, 1'b0);
        access(1'b1, 30'h00, 32'h0BAD_F00D, 1'b1, -1);
        rd(30'h10, 32'h0000_1111, 1'b0);
        exp_mem(1'b1, 28'h0, {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'h0BAD_F00D}, 1'b0);
        exp_mem(1'b0, 28'h8, 128'd0, 1'b0);
        rd(30'h20, 32'hA000_0020, 1'b1);
        exp_mem(1'b0, 28'hA, 128'd0, 1'b0);
        rd(30'h2B, 32'hA000_002B, 1'b1);
        cnt(32'd5, 32'd7);
        access(1'b1, 30'h2B, 32'h1234_5678, 1'b0, 0);
        exp_mem(1'b0, 28'h12, 128'd0, 1'b0);
        rd(30'h4B, 32'hA000_004B, 1'b1);
        cnt(32'd6, 32'd8);

        // Reset while the dirty victim is being written back
        exp_mem(1'b1, 28'hA, {32'h1234_5678, 32'hA000_002A, 32'hA000_0029, 32'hA000_0028}, 1'b1);
        req_addr = 30'h6B; req_read = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_mwrite) begin
                seen = 1'b1;
                break;
            end
        end
        check("wb_started", 128'(seen), 128'd1);
        #2;
        proc_reset_n = 1'b0; req_read = 1'b0;
        #1;
        check("rst_wb_mem_write", 128'(m_mwrite), 128'd0);
        check("rst_wb_stall", 128'(m_stall), 128'd0);
        cnt(32'd0, 32'd0);
        @(posedge clk); #1;
        proc_reset_n = 1'b1;
        exp_mem(1'b0, 28'h1A, 128'd0, 1'b0);
        rd(30'h6B, 32'hA000_006B, 1'b1);
        cnt(32'd0, 32'd1);

        // 4-way, 2 sets: five blocks in set 0 with the first re-touched
        @(posedge clk); #1;
        sel = 1'b1; proc_reset_n = 1'b0;
        bmem.delete();
        @(posedge clk); #1;
        proc_reset_n = 1'b1;
        exp_mem(1'b0, 28'h0, 128'd0, 1'b0);
        rd(30'h00, 32'hA000_0000, 1'b1);
        exp_mem(1'b0, 28'h2, 128'd0, 1'b0);
        rd(30'h08, 32'hA000_0008, 1'b1);
        exp_mem(1'b0, 28'h4, 128'd0, 1'b0);
        rd(30'h10, 32'hA000_0010, 1'b1);
        exp_mem(1'b0, 28'h6, 128'd0, 1'b0);
        rd(30'h18, 32'hA000_0018, 1'b1);
        rd(30'h00, 32'hA000_0000, 1'b0);
        exp_mem(1'b0, 28'h8, 128'd0, 1'b0);
        rd(30'h20, 32'hA000_0020, 1'b1);
        rd(30'h00, 32'hA000_0000, 1'b0);
        rd(30'h10, 32'hA000_0010, 1'b0);
        rd(30'h18, 32'hA000_0018, 1'b0);
        rd(30'h20, 32'hA000_0020, 1'b0);
        exp_mem(1'b0, 28'h2, 128'd0, 1'b0);
        rd(30'h08, 32'hA000_0008, 1'b1);
        exp_mem(1'b0, 28'h0, 128'd0, 1'b0);
        rd(30'h00, 32'hA000_0000, 1'b1);
        cnt(32'd5, 32'd7);

        repeat (3) @(posedge clk);
        check("rd_q_drained", 128'(rd_q.size()), 128'd0);
        check("mem_q_drained", 128'(mem_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_nway_lru.md
Name: cache_nway_lru

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache between the pipeline MEM stage and a 128-bit block memory.
- Generalises the current 2-way cache in three ways: configurable set count and way count, true-LRU replacement, and saturating hit/miss performance counters.
- Lines are 4 words; hits complete with zero stall; misses stall the processor until the line is refilled.

Parameters:
- ADDR_W, 30, processor word-address width.
- SETS, 4, number of sets; power of 2, at least 2; IDX_W = log2(SETS).
- WAYS, 2, associativity; one of 2, 4 or 8; AGE_W = log2(WAYS).
- TAG_W, ADDR_W-2-IDX_W, derived tag width; not to be overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- proc_reset_n  in  1  asynchronous, active-low reset.
- proc_read  in  1  read request, level, held while proc_stall=1.
- proc_write  in  1  write request, level, held while proc_stall=1.
- proc_addr  in  ADDR_W  word address.
- proc_wdata  in  32  write data.
- proc_rdata  out  32  read data; valid in a cycle with proc_read=1 and proc_stall=0.
- proc_stall  out  1  stall request to the pipeline.
- mem_read  out  1  block read request.
- mem_write  out  1  block write-back request.
- mem_addr  out  ADDR_W-2  block address.
- mem_rdata  in  128  refill block; word0 is [31:0].
- mem_wdata  out  128  write-back block, same packing as mem_rdata.
- mem_ready  in  1  one-cycle completion pulse for the current memory request.
- hit_cnt  out  32  counted hits, saturating.
- miss_cnt  out  32  counted misses, saturating.

Behaviour:
- Address split: offset = proc_addr[1:0]; index = proc_addr[IDX_W+1:2]; tag = proc_addr[ADDR_W-1:IDX_W+2].
- Per line state: valid, dirty, tag, 4x32 data. Per set: one AGE_W-bit age per way, where 0 = most recently used.
- Reset (async, proc_reset_n=0):
  - State goes to IDLE; all valid and dirty bits clear; data and tags go to 0.
  - Ages in every set are initialised to their way index.
  - Counters and the replay flag clear.
  - All outputs go to 0: proc_stall=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, proc_rdata=0.
  - Reset mid-miss abandons the transfer; dirty data is lost.
- FSM states: IDLE, WRITE_BACK, ALLOCATE. mem_read and mem_write are Moore outputs.
- IDLE, no request: proc_stall=0, no state change.
- IDLE, request and hit in any way:
  - proc_stall=0.
  - Read: proc_rdata = the hit word, combinationally.
  - Write: the word is updated and the line's dirty bit set at the clock edge.
  - Hit way's age goes to 0; ways with age below its old age increment.
- proc_read and proc_write both high: treated as a write.
- IDLE, request and miss:
  - proc_stall=1 combinationally.
  - Victim selection: lowest-index invalid way; otherwise the way with age WAYS-1. The victim way index is registered.
  - Next state: WRITE_BACK if the victim is valid and dirty, else ALLOCATE.
- WRITE_BACK:
  - proc_stall=1, mem_write=1.
  - mem_addr = {victim tag, index}; mem_wdata = victim line; both held stable.
  - On mem_ready: go to ALLOCATE.
- ALLOCATE:
  - proc_stall=1, mem_read=1, mem_addr = proc_addr[ADDR_W-1:2].
  - On mem_ready, the victim line is loaded with mem_rdata, valid=1, dirty=0, tag written, and LRU updated as an access to the victim way.
  - State returns to IDLE and replay=1.
- Replay: the request is re-evaluated in IDLE the cycle after the fill. It hits (stall drops) and a write merges then.
- Miss latency from request to stall=0, where Lw and Lr are the cycle counts from request assertion to mem_ready, inclusive:
  - clean victim: 1 + Lr + 1 cycles.
  - dirty victim: 1 + Lw + Lr + 1 cycles.
- Request dropped mid-miss: the transfer still completes; no write merge occurs.
- Counters:
  - miss_cnt +1 on each IDLE miss detection.
  - hit_cnt +1 on each IDLE hit with replay=0; replay clears after any IDLE cycle.
  - Both saturate at 32'hFFFFFFFF.
- proc_addr must not change while proc_stall=1. mem_ready outside WRITE_BACK/ALLOCATE is ignored.

Test Plan:
- Reset, then read addr 0x10: stall=1, one cycle later mem_read=1, mem_addr=0x4. mem_ready with mem_rdata=128'h4444_3333_2222_1111: next cycle stall=0, rdata=0x1111; hit_cnt=0, miss_cnt=1.
- Write 0xDEADBEEF to 0x11, then read 0x11: zero stall, rdata=0xDEADBEEF; hit_cnt=2.
- Defaults (SETS=4, WAYS=2):
  - Fill 0x00 and 0x10 (same set 0), read 0x00, then read 0x20: way holding 0x10 evicted (LRU).
  - Read 0x10 misses again.
- Dirty eviction:
  - Write 0x00, fill 0x10, read 0x10, then access 0x20.
  - Required: mem_write=1 with mem_addr=0x0 and mem_wdata containing the written word; after mem_ready, mem_read with mem_addr=0x8.
- WAYS=4, SETS=2: five distinct blocks in set 0 with re-touch of the first; the victim is the least-recently-touched block; verify by re-read miss/hit pattern.
- Assert proc_reset_n=0 during WRITE_BACK: mem_write, proc_stall and counters go to 0 immediately; a subsequent read of the same address misses.
